// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Serial UART receiver. Uses a 16x oversampling enable tick to
//            recover DBIT-bit frames, sent LSB first, from the asynchronous
//            rx line. Optional odd or even parity is checked, and the stop
//            bit is checked for a framing error. Each received word is held
//            in a one-entry buffer with a valid/ack handshake. Overrun is
//            reported when a new word replaces an unread one.
// Ports    : clk          - clock
//            reset        - asynchronous, active-high reset
//            s_tick       - 1-clk enable pulse at 16x baud
//            rx           - serial input, asynchronous, idle high
//            rd_ack       - consumer has taken dout; clears dout_valid
//            dout         - last received word
//            dout_valid   - dout holds an unread word
//            frame_err    - stop bit of the word in dout was sampled low
//            parity_err   - parity mismatch on the word in dout
//            overrun      - a word completed while the previous one was unread
//            rx_done_tick - 1-clk pulse at frame completion
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DBIT    = 8,   // data bits per frame, 5..8
  parameter int SB_TICK = 16,  // s_ticks in the stop bit (16/24/32)
  parameter int PARITY  = 0    // 0 = none, 1 = odd, 2 = even
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rd_ack,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            rx_done_tick
);

  localparam int SW = $clog2(SB_TICK) + 1;
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] c_s_mid  = SW'(7);
  localparam logic [SW-1:0] c_s_bit  = SW'(15);
  localparam logic [SW-1:0] c_s_stop = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] c_n_last = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic            r_ferr;
  logic            r_perr;
  logic            r_rx_meta;
  logic            r_rx_sync;

  // Two-flop synchronizer. It resets to the idle level so that reset does not
  // look like a start bit. It runs every clk, whatever s_tick is doing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receive FSM. It advances only on s_tick cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_b          <= '0;
      r_ferr       <= 1'b0;
      r_perr       <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      if (s_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_rx_sync) begin
              r_state <= ST_START;
              r_s     <= '0;
            end
          end
          ST_START: begin
            // Check the middle of the start bit. A line that is high again
            // at this point was a glitch, and nothing is reported.
            if (r_s == c_s_mid) begin
              r_s <= '0;
              if (!r_rx_sync) begin
                r_state <= ST_DATA;
                r_n     <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
          ST_DATA: begin
            // Counting from mid-start, every 16 ticks lands on a bit centre.
            if (r_s == c_s_bit) begin
              r_s <= '0;
              r_b <= {r_rx_sync, r_b[DBIT-1:1]};
              if (r_n == c_n_last) begin
                r_state <= (PARITY != 0) ? ST_PAR : ST_STOP;
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
          ST_PAR: begin
            // Odd parity needs the XOR of data and parity to be 1. Even
            // parity needs it to be 0.
            if (r_s == c_s_bit) begin
              r_s     <= '0;
              r_perr  <= (^r_b) ^ r_rx_sync ^ (PARITY == 1);
              r_state <= ST_STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
          ST_STOP: begin
            // The FSM does not wait for the line to return high. Under a
            // break, it re-enters START straight away.
            if (r_s == c_s_stop) begin
              r_s          <= '0;
              r_ferr       <= ~r_rx_sync;
              rx_done_tick <= 1'b1;
              r_state      <= ST_IDLE;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_s     <= '0;
          end
        endcase
      end
    end
  end

  // One-entry output buffer. It is loaded in the cycle after rx_done_tick.
  // A new word always replaces the old one. An ack in the completion cycle
  // consumes the old word, so that case is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (rx_done_tick) begin
      dout       <= r_b;
      frame_err  <= r_ferr;
      parity_err <= r_perr;
      dout_valid <= 1'b1;
      overrun    <= dout_valid & ~rd_ack;
    end else if (rd_ack && dout_valid) begin
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
`default_nettype wire
